tcdm_mem_req_queue: RTL and testbench
=====================================

Name: tcdm_mem_req_queue

Overview:
Downstream stage of the data-cache wrapper. It sits between the cache's memory-side OBI port and the TCDM slave bus that leads to L2. It buffers cache refill and writeback requests in a FIFO and issues them onto TCDM with OBI hold-until-grant semantics. It caps the number of in-flight transactions and returns registered, in-order responses to the cache. It replaces the single-outstanding adapter and lets the cache post writebacks without stalling on L2 grant latency.

Parameters:
DEPTH, 4, request FIFO entries; power of two, >= 2
MAX_OUTSTANDING, 2, max granted-but-unanswered TCDM transactions; >= 1
ADDR_WIDTH, 32, address width; fixed by the TCDM bus
DATA_WIDTH, 32, data width; fixed by the TCDM bus
BE_WIDTH, 4, byte-enable width; fixed by the TCDM bus

Ports:
clk_i  in  1  clock
rst_ni  in  1  asynchronous active-low reset
up_req_i  in  1  cache request valid
up_gnt_o  out  1  request accepted this cycle when up_req_i is also high
up_addr_i  in  ADDR_WIDTH  request address
up_we_i  in  1  1 = write
up_be_i  in  BE_WIDTH  byte enables
up_wdata_i  in  DATA_WIDTH  write data
up_rvalid_o  out  1  response valid (registered)
up_rdata_o  out  DATA_WIDTH  response data
up_err_o  out  1  response error
dn_req_o  out  1  TCDM request
dn_gnt_i  in  1  TCDM grant
dn_add_o  out  ADDR_WIDTH  TCDM address
dn_wen_o  out  1  TCDM write-enable, active-low (1 = read)
dn_be_o  out  BE_WIDTH  TCDM byte enables
dn_wdata_o  out  DATA_WIDTH  TCDM write data
dn_r_valid_i  in  1  TCDM response valid
dn_r_rdata_i  in  DATA_WIDTH  TCDM response data
dn_r_opc_i  in  1  TCDM response error
fifo_level_o  out  $clog2(DEPTH)+1  current FIFO occupancy
outstanding_o  out  $clog2(MAX_OUTSTANDING)+1  in-flight count
unexp_rsp_o  out  1  sticky flag: response arrived with zero in flight

Behaviour:
Reset and clock:
- Reset rst_ni, asynchronous, active-low; clock clk_i.
- Reset empties the FIFO and clears the outstanding counter and unexp_rsp_o.
- Reset drives all outputs to 0, except up_gnt_o = 1 (FIFO empty) and dn_wen_o = 1.

Request FIFO:
- Entry = {we, be, addr, wdata}.
- up_gnt_o = !full, combinational and independent of up_req_i.
- Push when up_req_i & up_gnt_o.
- No bypass: a request accepted in cycle N drives dn_req_o no earlier than cycle N+1.

Downstream issue:
- dn_req_o = !empty & (outstanding < MAX_OUTSTANDING).
- dn_add_o, dn_be_o and dn_wdata_o come from the FIFO head.
- dn_wen_o = !head.we when a request is presented, else 1.
- Pop when dn_req_o & dn_gnt_i.
- Once dn_req_o rises it holds, with stable payload, until granted. The counter can only rise on a grant, so no other event may drop it.

Outstanding counter:
- +1 on pop, -1 on a counted dn_r_valid_i; both in the same cycle leave it unchanged.
- Never exceeds MAX_OUTSTANDING.

Response path:
- On dn_r_valid_i with outstanding > 0, register in the next cycle: up_rvalid_o = 1, up_rdata_o = dn_r_rdata_i, up_err_o = dn_r_opc_i.
- up_rvalid_o is low otherwise; rdata/err hold their last value.
- Responses stay in order; TCDM is in-order.
- The cache consumes every response; there is no backpressure.

Boundary conditions:
- Full: up_gnt_o = 0. A pop in the same cycle raises up_gnt_o only in the following cycle.
- Empty: dn_req_o = 0.
- Push and pop in the same cycle: level unchanged.
- Pointers wrap modulo DEPTH.
- dn_r_valid_i with outstanding == 0: not forwarded, counter unchanged, unexp_rsp_o set until reset. This includes responses to transactions granted before a mid-operation reset.

Test Plan:
- Single read: up_req addr 0x1C000100 we=0 at cycle 0. Expect up_gnt=1 at cycle 0 and dn_req=1, dn_wen=1, dn_add=0x1C000100 at cycle 1. dn_gnt at cycle 1, r_valid at cycle 3 with rdata 0xDEADBEEF. Expect up_rvalid=1, up_rdata=0xDEADBEEF at cycle 4, outstanding back to 0.
- Fill: 4 back-to-back writes, dn_gnt held 0. Expect fifo_level=4, up_gnt=0 on the 5th request, dn_req stays high with the first payload stable (dn_wen=0, be=0xF).
- Outstanding cap: 3 reads queued, dn_gnt=1, no responses. Expect exactly 2 grants, dn_req=0, outstanding=2. One r_valid -> dn_req reasserts the next cycle and the third read issues.
- Simultaneous: pop plus r_valid in the same cycle at outstanding=1 -> outstanding stays 1. Push plus pop at level=2 -> level stays 2.
- Error: r_valid with r_opc=1 -> up_err=1 with up_rvalid the next cycle.
- Spurious/reset: r_valid with outstanding=0 -> no up_rvalid, unexp_rsp=1. Assert rst_ni low mid-burst with level=3 -> level=0, dn_req=0, unexp_rsp=0 immediately.

Source files
------------

// File: rtl/tcdm_mem_req_queue_if.sv
// Handshake bundles for the TCDM request queue: cache-side OBI port (up)
// and the TCDM slave bus towards L2 (dn).
interface tcdm_mem_req_queue_up_if #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned BE_WIDTH   = 4
);
  logic                  req;
  logic                  gnt;
  logic [ADDR_WIDTH-1:0] addr;
  logic                  we;
  logic [BE_WIDTH-1:0]   be;
  logic [DATA_WIDTH-1:0] wdata;
  logic                  rvalid;
  logic [DATA_WIDTH-1:0] rdata;
  logic                  err;

  modport master (
    output req, addr, we, be, wdata,
    input  gnt, rvalid, rdata, err
  );

  modport slave (
    input  req, addr, we, be, wdata,
    output gnt, rvalid, rdata, err
  );
endinterface

interface tcdm_mem_req_queue_dn_if #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned BE_WIDTH   = 4
);
  logic                  req;
  logic                  gnt;
  logic [ADDR_WIDTH-1:0] add;
  logic                  wen;
  logic [BE_WIDTH-1:0]   be;
  logic [DATA_WIDTH-1:0] wdata;
  logic                  r_valid;
  logic [DATA_WIDTH-1:0] r_rdata;
  logic                  r_opc;

  modport master (
    output req, add, wen, be, wdata,
    input  gnt, r_valid, r_rdata, r_opc
  );

  modport slave (
    input  req, add, wen, be, wdata,
    output gnt, r_valid, r_rdata, r_opc
  );
endinterface

// File: rtl/tcdm_mem_req_queue.sv
// Request FIFO between the data-cache memory port and the TCDM bus: queues
// refills/writebacks, caps in-flight transactions, returns registered responses.
module tcdm_mem_req_queue #(
  parameter int unsigned DEPTH           = 4,
  parameter int unsigned MAX_OUTSTANDING = 2,
  parameter int unsigned ADDR_WIDTH      = 32,
  parameter int unsigned DATA_WIDTH      = 32,
  parameter int unsigned BE_WIDTH        = 4
) (
  input  logic                             clk_i,
  input  logic                             rst_ni,
  tcdm_mem_req_queue_up_if.slave           up,
  tcdm_mem_req_queue_dn_if.master          dn,
  output logic [$clog2(DEPTH):0]           fifo_level_o,
  output logic [$clog2(MAX_OUTSTANDING):0] outstanding_o,
  output logic                             unexp_rsp_o
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned LvlW = PtrW + 1;
  localparam int unsigned OutW = $clog2(MAX_OUTSTANDING) + 1;

  typedef struct packed {
    logic                  we;
    logic [BE_WIDTH-1:0]   be;
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] wdata;
  } entry_t;

  entry_t                mem_q [DEPTH];
  logic [PtrW-1:0]       wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]       rd_ptr_q, rd_ptr_d;
  logic [LvlW-1:0]       level_q, level_d;
  logic [OutW-1:0]       out_q, out_d;
  logic                  rvalid_q, rvalid_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic                  err_q, err_d;
  logic                  unexp_q, unexp_d;

  logic   full, empty, out_room, issue, push, pop, rsp_cnt;
  entry_t head, up_entry;

  assign full     = (level_q == LvlW'(DEPTH));
  assign empty    = (level_q == '0);
  assign out_room = (out_q < OutW'(MAX_OUTSTANDING));
  assign head     = mem_q[rd_ptr_q];

  // Issue only depends on state that a grant alone can change, so a raised
  // request can never drop before it is granted.
  assign issue   = !empty && out_room;
  assign push    = up.req && !full;
  assign pop     = issue && dn.gnt;
  assign rsp_cnt = dn.r_valid && (out_q != '0);

  assign up_entry.we    = up.we;
  assign up_entry.be    = up.be;
  assign up_entry.addr  = up.addr;
  assign up_entry.wdata = up.wdata;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    out_d    = out_q;
    rvalid_d = rsp_cnt;
    rdata_d  = rdata_q;
    err_d    = err_q;
    unexp_d  = unexp_q;

    if (push) wr_ptr_d = wr_ptr_q + PtrW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PtrW'(1);

    if (push && !pop)      level_d = level_q + LvlW'(1);
    else if (pop && !push) level_d = level_q - LvlW'(1);

    if (pop && !rsp_cnt)      out_d = out_q + OutW'(1);
    else if (rsp_cnt && !pop) out_d = out_q - OutW'(1);

    if (rsp_cnt) begin
      rdata_d = dn.r_rdata;
      err_d   = dn.r_opc;
    end

    // Includes stale responses to transactions granted before a reset.
    if (dn.r_valid && (out_q == '0)) unexp_d = 1'b1;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      out_q    <= '0;
      rvalid_q <= 1'b0;
      rdata_q  <= '0;
      err_q    <= 1'b0;
      unexp_q  <= 1'b0;
    end else begin
      if (push) mem_q[wr_ptr_q] <= up_entry;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      out_q    <= out_d;
      rvalid_q <= rvalid_d;
      rdata_q  <= rdata_d;
      err_q    <= err_d;
      unexp_q  <= unexp_d;
    end
  end

  assign up.gnt    = !full;
  assign up.rvalid = rvalid_q;
  assign up.rdata  = rdata_q;
  assign up.err    = err_q;

  assign dn.req   = issue;
  assign dn.add   = head.addr;
  assign dn.wen   = issue ? !head.we : 1'b1;
  assign dn.be    = head.be;
  assign dn.wdata = head.wdata;

  assign fifo_level_o  = level_q;
  assign outstanding_o = out_q;
  assign unexp_rsp_o   = unexp_q;

endmodule

// File: tb/tb_tcdm_mem_req_queue.sv
// Directed bench for tcdm_mem_req_queue: expected responses go to a scoreboard
// queue checked by a monitor; a second monitor checks hold-until-grant.
module tb_tcdm_mem_req_queue;

  logic       clk_i = 1'b0;
  logic       rst_ni = 1'b0;
  logic [2:0] fifo_level;
  logic [1:0] outstanding;
  logic       unexp_rsp;

  int n_assert = 0;
  int n_fail   = 0;

  logic [32:0] exp_q [$];

  tcdm_mem_req_queue_up_if up_if ();
  tcdm_mem_req_queue_dn_if dn_if ();

  tcdm_mem_req_queue #(
    .DEPTH(4), .MAX_OUTSTANDING(2), .ADDR_WIDTH(32), .DATA_WIDTH(32), .BE_WIDTH(4)
  ) dut (
    .clk_i         (clk_i),
    .rst_ni        (rst_ni),
    .up            (up_if),
    .dn            (dn_if),
    .fifo_level_o  (fifo_level),
    .outstanding_o (outstanding),
    .unexp_rsp_o   (unexp_rsp)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk_i);
    #1;
  endtask

  task automatic idle();
    up_if.req     = 1'b0;
    up_if.addr    = '0;
    up_if.we      = 1'b0;
    up_if.be      = '0;
    up_if.wdata   = '0;
    dn_if.gnt     = 1'b0;
    dn_if.r_valid = 1'b0;
    dn_if.r_rdata = '0;
    dn_if.r_opc   = 1'b0;
  endtask

  task automatic push_req(input logic [31:0] a, input logic we, input logic [31:0] wd);
    up_if.req   = 1'b1;
    up_if.addr  = a;
    up_if.we    = we;
    up_if.be    = 4'hF;
    up_if.wdata = wd;
  endtask

  task automatic respond(input logic [31:0] d, input logic opc);
    dn_if.r_valid = 1'b1;
    dn_if.r_rdata = d;
    dn_if.r_opc   = opc;
    exp_q.push_back({opc, d});
  endtask

  // Reset asserted mid-cycle: outputs must clear without waiting for a clock.
  task automatic do_reset(input string tag);
    rst_ni = 1'b0;
    idle();
    #1;
    chk({tag, "_level"},   64'(fifo_level), 64'd0);
    chk({tag, "_dn_req"},  64'(dn_if.req), 64'd0);
    chk({tag, "_unexp"},   64'(unexp_rsp), 64'd0);
    chk({tag, "_out"},     64'(outstanding), 64'd0);
    chk({tag, "_up_gnt"},  64'(up_if.gnt), 64'd1);
    chk({tag, "_dn_wen"},  64'(dn_if.wen), 64'd1);
    chk({tag, "_rvalid"},  64'(up_if.rvalid), 64'd0);
    cyc();
    rst_ni = 1'b1;
  endtask

  // Scoreboard monitor.
  always @(negedge clk_i) begin
    if (rst_ni && up_if.rvalid) begin
      if (exp_q.size() == 0) begin
        chk("rsp_unexpected", 64'(up_if.rvalid), 64'd0);
      end else begin
        logic [32:0] e;
        e = exp_q.pop_front();
        chk("rsp_data_err", 64'({up_if.err, up_if.rdata}), 64'(e));
      end
    end
  end

  // Hold-until-grant monitor.
  logic        hold_pend = 1'b0;
  logic [68:0] hold_pay;
  always @(negedge clk_i) begin
    if (!rst_ni) begin
      hold_pend = 1'b0;
    end else begin
      if (hold_pend) begin
        chk("hold_req", 64'(dn_if.req), 64'd1);
        chk("hold_payload_lo", 64'({dn_if.add, dn_if.wdata}), 64'(hold_pay[63:0]));
        chk("hold_payload_hi", 64'({dn_if.wen, dn_if.be}), 64'(hold_pay[68:64]));
      end
      hold_pend = dn_if.req && !dn_if.gnt;
      hold_pay  = {dn_if.wen, dn_if.be, dn_if.add, dn_if.wdata};
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    idle();
    #1;
    chk("rst_up_gnt", 64'(up_if.gnt), 64'd1);
    chk("rst_dn_req", 64'(dn_if.req), 64'd0);
    chk("rst_dn_wen", 64'(dn_if.wen), 64'd1);
    chk("rst_level",  64'(fifo_level), 64'd0);
    chk("rst_rvalid", 64'(up_if.rvalid), 64'd0);
    cyc();
    rst_ni = 1'b1;
    cyc();

    // Single read
    push_req(32'h1C00_0100, 1'b0, 32'h0);
    #1;
    chk("rd_up_gnt", 64'(up_if.gnt), 64'd1);
    chk("rd_no_bypass", 64'(dn_if.req), 64'd0);
    cyc();
    idle();
    #1;
    chk("rd_dn_req", 64'(dn_if.req), 64'd1);
    chk("rd_dn_wen", 64'(dn_if.wen), 64'd1);
    chk("rd_dn_add", 64'(dn_if.add), 64'h1C00_0100);
    dn_if.gnt = 1'b1;
    cyc();
    dn_if.gnt = 1'b0;
    #1;
    chk("rd_out1", 64'(outstanding), 64'd1);
    chk("rd_empty_req", 64'(dn_if.req), 64'd0);
    cyc();
    respond(32'hDEAD_BEEF, 1'b0);
    cyc();
    idle();
    #1;
    chk("rd_rvalid", 64'(up_if.rvalid), 64'd1);
    chk("rd_rdata", 64'(up_if.rdata), 64'hDEAD_BEEF);
    chk("rd_out0", 64'(outstanding), 64'd0);
    cyc();
    chk("rd_rvalid_low", 64'(up_if.rvalid), 64'd0);

    // Fill with writes, no grant
    for (int i = 0; i < 4; i++) begin
      push_req(32'hA000_0000 + 32'(i * 4), 1'b1, 32'hD000_0000 + 32'(i));
      cyc();
    end
    push_req(32'hBAD0_0000, 1'b1, 32'hFFFF_FFFF);
    #1;
    chk("fill_level", 64'(fifo_level), 64'd4);
    chk("fill_up_gnt", 64'(up_if.gnt), 64'd0);
    chk("fill_dn_req", 64'(dn_if.req), 64'd1);
    chk("fill_dn_add", 64'(dn_if.add), 64'hA000_0000);
    chk("fill_dn_wen", 64'(dn_if.wen), 64'd0);
    chk("fill_dn_be", 64'(dn_if.be), 64'hF);
    chk("fill_dn_wdata", 64'(dn_if.wdata), 64'hD000_0000);
    cyc();
    chk("fill_reject", 64'(fifo_level), 64'd4);
    dn_if.gnt = 1'b1;
    #1;
    chk("full_pop_gnt_same", 64'(up_if.gnt), 64'd0);
    cyc();
    up_if.req = 1'b0;
    dn_if.gnt = 1'b0;
    #1;
    chk("full_pop_level", 64'(fifo_level), 64'd3);
    chk("full_pop_gnt_next", 64'(up_if.gnt), 64'd1);
    chk("full_pop_next_add", 64'(dn_if.add), 64'hA000_0004);
    do_reset("rst1");
    cyc();

    // Outstanding cap and simultaneous pop/response
    for (int i = 0; i < 3; i++) begin
      push_req(32'hB000_0000 + 32'(i * 4), 1'b0, 32'h0);
      cyc();
    end
    up_if.req = 1'b0;
    dn_if.gnt = 1'b1;
    #1;
    chk("cap_level3", 64'(fifo_level), 64'd3);
    chk("cap_add0", 64'(dn_if.add), 64'hB000_0000);
    cyc();
    chk("cap_out1", 64'(outstanding), 64'd1);
    chk("cap_add1", 64'(dn_if.add), 64'hB000_0004);
    cyc();
    chk("cap_req_low", 64'(dn_if.req), 64'd0);
    chk("cap_out2", 64'(outstanding), 64'd2);
    chk("cap_level1", 64'(fifo_level), 64'd1);
    cyc();
    chk("cap_still_low", 64'(dn_if.req), 64'd0);
    chk("cap_still_out2", 64'(outstanding), 64'd2);
    respond(32'h1111_0000, 1'b0);
    cyc();
    respond(32'h2222_0000, 1'b0);
    #1;
    chk("cap_reissue_req", 64'(dn_if.req), 64'd1);
    chk("cap_reissue_add", 64'(dn_if.add), 64'hB000_0008);
    chk("sim_out_before", 64'(outstanding), 64'd1);
    cyc();
    respond(32'h3333_0000, 1'b0);
    #1;
    chk("sim_out_same", 64'(outstanding), 64'd1);
    chk("sim_level0", 64'(fifo_level), 64'd0);
    chk("sim_empty_req", 64'(dn_if.req), 64'd0);
    cyc();
    idle();
    #1;
    chk("sim_out_drain", 64'(outstanding), 64'd0);
    cyc();

    // Push and pop at level 2
    push_req(32'hC000_0000, 1'b0, 32'h0);
    cyc();
    push_req(32'hC000_0004, 1'b0, 32'h0);
    cyc();
    push_req(32'hC000_0008, 1'b0, 32'h0);
    dn_if.gnt = 1'b1;
    #1;
    chk("pp_level_before", 64'(fifo_level), 64'd2);
    cyc();
    idle();
    #1;
    chk("pp_level_same", 64'(fifo_level), 64'd2);
    chk("pp_out1", 64'(outstanding), 64'd1);
    chk("pp_next_add", 64'(dn_if.add), 64'hC000_0004);

    // Error response
    respond(32'hE000_0001, 1'b1);
    cyc();
    idle();
    #1;
    chk("err_rvalid", 64'(up_if.rvalid), 64'd1);
    chk("err_flag", 64'(up_if.err), 64'd1);
    chk("err_out0", 64'(outstanding), 64'd0);
    cyc();

    // Spurious response with nothing in flight
    dn_if.r_valid = 1'b1;
    dn_if.r_rdata = 32'h5A5A_5A5A;
    cyc();
    idle();
    #1;
    chk("spur_no_rvalid", 64'(up_if.rvalid), 64'd0);
    chk("spur_unexp", 64'(unexp_rsp), 64'd1);
    chk("spur_out0", 64'(outstanding), 64'd0);
    chk("spur_level", 64'(fifo_level), 64'd2);
    push_req(32'hC000_000C, 1'b1, 32'h0);
    cyc();
    idle();
    #1;
    chk("burst_level3", 64'(fifo_level), 64'd3);

    // Mid-burst reset
    do_reset("rst2");
    cyc();
    chk("post_rst_gnt", 64'(up_if.gnt), 64'd1);
    chk("post_rst_req", 64'(dn_if.req), 64'd0);
    cyc();
    cyc();
    chk("sb_drained", 64'(exp_q.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
